// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the SRAM request arbiter.
// Request and response bundles for the two masters.
package sp_ram_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

endpackage

// File: rtl/sp_ram_arb_rr.sv
// Two-way round-robin arbiter.
// A tie goes to the master that was not served last.
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn_i,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt
);

  logic rr_last;

  // One-hot grant; a lone requester always wins
  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt[0] = rr_last;
      gnt[1] = ~rr_last;
    end
  end

  // Remember who was served most recently
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_last <= 1'b1;
    end else if (|gnt) begin
      rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/sp_ram_arb.sv
// Two-master front end for the single-port SRAM.
// Window decode, 1-cycle response, shared read data.
module sp_ram_arb
  import sp_ram_arb_pkg::*;
#(
  parameter int          RAM_SIZE   = 32768,
  parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rstn_i,

  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,

  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  ram_bypass_en_o
);

  obi_req_t m0_req, m1_req, sel_req;
  obi_rsp_t m0_rsp, m1_rsp;

  logic [NUM_MASTERS-1:0] req, gnt;
  logic acc, in_range;

  logic        resp_valid;
  logic        resp_owner;
  logic        resp_err;
  logic [31:0] rdata_hold;
  logic [31:0] rdata_drv;

  assign m0_req = '{addr: m0_addr_i, we: m0_we_i,
                    be: m0_be_i, wdata: m0_wdata_i};
  assign m1_req = '{addr: m1_addr_i, we: m1_we_i,
                    be: m1_be_i, wdata: m1_wdata_i};

  assign req = {m1_req_i, m0_req_i};

  rr_arb2 u_arb (
    .clk    (clk),
    .rstn_i (rstn_i),
    .req    (req),
    .gnt    (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign acc      = |gnt;

  // Route the winner; idle cycles show m0
  always_comb begin
    sel_req = m0_req;
    unique case (1'b1)
      gnt[1]:  sel_req = m1_req;
      default: sel_req = m0_req;
    endcase
  end

  assign in_range = sel_req.addr[31:ADDR_WIDTH]
                 == BASE_ADDR[31:ADDR_WIDTH];

  assign ram_en_o        = acc & in_range;
  assign ram_we_o        = ram_en_o & sel_req.we;
  assign ram_addr_o      = sel_req.addr[ADDR_WIDTH-1:0];
  assign ram_be_o        = sel_req.be;
  assign ram_wdata_o     = sel_req.wdata;
  assign ram_bypass_en_o = 1'b0;

  // Track the response owed one cycle after acceptance
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= acc;
      resp_owner <= gnt[1];
      resp_err   <= acc & ~in_range;
    end
  end

  // Shared read data: live, zero on error, else held
  always_comb begin
    rdata_drv = rdata_hold;
    if (resp_valid) begin
      rdata_drv = resp_err ? 32'h0 : ram_rdata_i;
    end
  end

  // Keep the last driven response data stable
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_hold <= 32'h0;
    end else if (resp_valid) begin
      rdata_hold <= rdata_drv;
    end
  end

  assign m0_rsp = '{rvalid: resp_valid & ~resp_owner,
                    rdata:  rdata_drv,
                    err:    resp_valid & ~resp_owner & resp_err};
  assign m1_rsp = '{rvalid: resp_valid & resp_owner,
                    rdata:  rdata_drv,
                    err:    resp_valid & resp_owner & resp_err};

  assign m0_rvalid_o = m0_rsp.rvalid;
  assign m0_rdata_o  = m0_rsp.rdata;
  assign m0_err_o    = m0_rsp.err;
  assign m1_rvalid_o = m1_rsp.rvalid;
  assign m1_rdata_o  = m1_rsp.rdata;
  assign m1_err_o    = m1_rsp.err;

endmodule

// File: tb/tb_sp_ram_arb.sv
// Bench for sp_ram_arb: SRAM stand-in, reference model,
// per-cycle compare and directed scenarios.
module tb_sp_ram_arb;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          RSZ  = 32768;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        m0_req_i, m1_req_i;
  logic        m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_err_o, m1_err_o;
  logic        ram_en_o, ram_we_o;
  logic [14:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata_i = 32'h0;
  logic        ram_bypass_en_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sp_ram_arb dut (
    .clk             (clk),
    .rstn_i          (rstn_i),
    .m0_req_i        (m0_req_i),
    .m0_gnt_o        (m0_gnt_o),
    .m0_addr_i       (m0_addr_i),
    .m0_we_i         (m0_we_i),
    .m0_be_i         (m0_be_i),
    .m0_wdata_i      (m0_wdata_i),
    .m0_rvalid_o     (m0_rvalid_o),
    .m0_rdata_o      (m0_rdata_o),
    .m0_err_o        (m0_err_o),
    .m1_req_i        (m1_req_i),
    .m1_gnt_o        (m1_gnt_o),
    .m1_addr_i       (m1_addr_i),
    .m1_we_i         (m1_we_i),
    .m1_be_i         (m1_be_i),
    .m1_wdata_i      (m1_wdata_i),
    .m1_rvalid_o     (m1_rvalid_o),
    .m1_rdata_o      (m1_rdata_o),
    .m1_err_o        (m1_err_o),
    .ram_en_o        (ram_en_o),
    .ram_addr_o      (ram_addr_o),
    .ram_wdata_o     (ram_wdata_o),
    .ram_we_o        (ram_we_o),
    .ram_be_o        (ram_be_o),
    .ram_rdata_i     (ram_rdata_i),
    .ram_bypass_en_o (ram_bypass_en_o)
  );

  // SRAM stand-in: 1-cycle read, byte-enabled write
  logic [31:0] sram [0:RSZ/4-1];
  initial begin
    for (int i = 0; i < RSZ / 4; i++) sram[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b])
            sram[ram_addr_o[14:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= sram[ram_addr_o[14:2]];
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: whole-word memory view plus the
  // one response owed for last cycle's accepted request
  logic [31:0] shadow [int unsigned];
  int          served_last;
  bit          pend_v, pend_err, pend_rd;
  int          pend_who;
  logic [31:0] pend_data;
  bit          hold_known;
  logic [31:0] hold_val;

  function automatic bit inwin(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + RSZ);
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int unsigned k = (a - BASE) / 4;
    return shadow.exists(k) ? shadow[k] : 32'h0;
  endfunction

  always @(negedge clk) begin
    int          win;
    logic [31:0] a, wd, cur, expd;
    logic [3:0]  be;
    logic        we;
    if (!rstn_i) begin
      chk("reset_outputs",
          {26'h0, m0_gnt_o, m1_gnt_o, m0_rvalid_o,
           m1_rvalid_o, m0_err_o, m1_err_o}, 32'h0);
      chk("reset_ram", {29'h0, ram_en_o, ram_we_o,
                        ram_bypass_en_o}, 32'h0);
      chk("reset_rdata", m0_rdata_o | m1_rdata_o, 32'h0);
      served_last = 1;
      pend_v      = 0;
      hold_known  = 1;
      hold_val    = 32'h0;
    end else begin
      win = -1;
      if (m0_req_i && m1_req_i) win = (served_last == 0) ? 1 : 0;
      else if (m0_req_i) win = 0;
      else if (m1_req_i) win = 1;
      chk("gnt", {30'h0, m1_gnt_o, m0_gnt_o},
          (win < 0) ? 32'h0 : (32'h1 << win));
      a  = (win == 1) ? m1_addr_i  : m0_addr_i;
      we = (win == 1) ? m1_we_i    : m0_we_i;
      be = (win == 1) ? m1_be_i    : m0_be_i;
      wd = (win == 1) ? m1_wdata_i : m0_wdata_i;
      chk("ram_en", {31'h0, ram_en_o},
          {31'h0, (win >= 0) && inwin(a)});
      chk("ram_we", {31'h0, ram_we_o},
          {31'h0, (win >= 0) && inwin(a) && we});
      chk("bypass", {31'h0, ram_bypass_en_o}, 32'h0);
      if ((win >= 0) && inwin(a)) begin
        chk("ram_addr", {17'h0, ram_addr_o}, a - BASE);
        chk("ram_be", {28'h0, ram_be_o}, {28'h0, be});
        if (we) chk("ram_wdata", ram_wdata_o, wd);
      end
      chk("rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o},
          pend_v ? (32'h1 << pend_who) : 32'h0);
      chk("err", {30'h0, m1_err_o, m0_err_o},
          (pend_v && pend_err) ? (32'h1 << pend_who) : 32'h0);
      chk("rdata_shared", m1_rdata_o, m0_rdata_o);
      if (pend_v && pend_err) chk("rdata_err", m0_rdata_o, 32'h0);
      else if (pend_v && pend_rd) chk("rdata", m0_rdata_o, pend_data);
      else if (!pend_v && hold_known)
        chk("rdata_hold", m0_rdata_o, hold_val);
      if (pend_v) begin
        hold_known = pend_err || pend_rd;
        hold_val   = pend_err ? 32'h0 : pend_data;
      end
      pend_v = (win >= 0);
      if (win >= 0) begin
        served_last = win;
        pend_who    = win;
        pend_err    = !inwin(a);
        pend_rd     = !we;
        pend_data   = 32'h0;
        if (inwin(a)) begin
          cur       = rd_word(a);
          pend_data = cur;
          if (we) begin
            expd = cur;
            for (int b = 0; b < 4; b++)
              if (be[b]) expd[8*b +: 8] = wd[8*b +: 8];
            shadow[(a - BASE) / 4] = expd;
          end
        end
      end
    end
  end

  task automatic drive(
    input logic r0, input logic [31:0] a0, input logic w0,
    input logic [3:0] b0, input logic [31:0] d0,
    input logic r1, input logic [31:0] a1, input logic w1,
    input logic [3:0] b1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    m0_req_i = r0; m0_addr_i = a0; m0_we_i = w0;
    m0_be_i  = b0; m0_wdata_i = d0;
    m1_req_i = r1; m1_addr_i = a1; m1_we_i = w1;
    m1_be_i  = b1; m1_wdata_i = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd0(input logic [31:0] a);
    drive(1, a, 0, 4'hF, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d);
    drive(0, 0, 0, 0, 0, 1, a, 1, b, d);
  endtask

  initial begin
    rstn_i = 1'b0;
    m0_req_i = 0; m0_addr_i = 0; m0_we_i = 0;
    m0_be_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_addr_i = 0; m1_we_i = 0;
    m1_be_i = 0; m1_wdata_i = 0;
    repeat (2) @(negedge clk);
    chk("lit_reset_rvalid", {31'h0, m0_rvalid_o | m1_rvalid_o}, 0);
    @(posedge clk);
    #1 rstn_i = 1'b1;

    // write then read back through the other master
    wr1(BASE + 32'h40, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lit_m1_gnt", {31'h0, m1_gnt_o}, 32'h1);
    chk("lit_wr_addr", {17'h0, ram_addr_o}, 32'h40);
    rd0(BASE + 32'h40);
    @(negedge clk);
    chk("lit_m1_rvalid", {30'h0, m1_rvalid_o, m1_err_o}, 32'h2);
    idle();
    @(negedge clk);
    chk("lit_m0_rvalid", {31'h0, m0_rvalid_o}, 32'h1);
    chk("lit_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);

    // byte-lane merge
    wr1(BASE + 32'h80, 4'hF, 32'h1122_3344);
    wr1(BASE + 32'h80, 4'b0100, 32'h00AB_0000);
    rd0(BASE + 32'h80);
    idle();
    @(negedge clk);
    chk("lit_byte_merge", m0_rdata_o, 32'h11AB_3344);

    // contention: m1 served last, so m0 leads
    wr1(BASE + 32'h100, 4'hF, 32'h5566_7788);
    for (int i = 0; i < 6; i++) begin
      drive(1, BASE + 32'h80, 0, 4'hF, 0,
            1, BASE + 32'h100, 0, 4'hF, 0);
      @(negedge clk);
      chk("lit_alt_gnt", {30'h0, m1_gnt_o, m0_gnt_o},
          (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    idle();
    @(negedge clk);
    chk("lit_alt_last", m1_rdata_o, 32'h5566_7788);

    // out-of-window and window edges
    rd0(32'h0000_0000);
    @(negedge clk);
    chk("lit_oow_en", {31'h0, ram_en_o}, 32'h0);
    rd0(BASE + 32'h7FFC);
    @(negedge clk);
    chk("lit_oow_err", {30'h0, m0_rvalid_o, m0_err_o}, 32'h3);
    chk("lit_oow_rdata", m0_rdata_o, 32'h0);
    chk("lit_top_addr", {17'h0, ram_addr_o}, 32'h7FFC);
    rd0(BASE + 32'h8000);
    @(negedge clk);
    chk("lit_top_ok", {30'h0, m0_rvalid_o, m0_err_o}, 32'h2);
    chk("lit_past_en", {31'h0, ram_en_o}, 32'h0);
    idle();
    @(negedge clk);
    chk("lit_past_err", {30'h0, m0_rvalid_o, m0_err_o}, 32'h3);

    // reset with a response pending
    drive(0, 0, 0, 0, 0, 1, BASE + 32'h40, 0, 4'hF, 0);
    @(posedge clk);
    #1;
    rstn_i = 1'b0;
    m1_req_i = 0;
    @(negedge clk);
    chk("lit_rst_drop", {31'h0, m1_rvalid_o}, 32'h0);
    @(posedge clk);
    #1 rstn_i = 1'b1;
    @(negedge clk);
    chk("lit_post_rst", {31'h0, m1_rvalid_o | m0_rvalid_o}, 0);
    drive(1, BASE + 32'h40, 0, 4'hF, 0,
          1, BASE + 32'h80, 0, 4'hF, 0);
    @(negedge clk);
    chk("lit_first_tie", {30'h0, m1_gnt_o, m0_gnt_o}, 32'h1);
    idle();
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_ram_arb.md
Name: sp_ram_arb

Overview:
- Request-side front end for the single-port SRAM wrapper; sits directly upstream of it.
- Arbitrates two OBI-style request/grant masters (m0 = instruction fetch, m1 = data LSU) onto the one SRAM port.
- Decodes byte addresses against a base window and returns rvalid/rdata/err with fixed 1-cycle latency.
- Out-of-window accesses never reach the RAM; they receive an error response.

Parameters:
- RAM_SIZE, 32768, RAM size in bytes (power of two).
- ADDR_WIDTH, $clog2(RAM_SIZE), RAM byte-address width driven to the RAM.
- DATA_WIDTH, 32, data width (fixed at 32 in this revision).
- BASE_ADDR, 32'h0010_0000, window base; must be aligned to RAM_SIZE.

Ports:
- clk  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- mX_req_i  in  1  request, X in {0,1}; held until granted
- mX_gnt_o  out  1  grant (combinational, same cycle)
- mX_addr_i  in  32  byte address
- mX_we_i  in  1  write enable
- mX_be_i  in  4  byte enables
- mX_wdata_i  in  32  write data
- mX_rvalid_o  out  1  response valid
- mX_rdata_o  out  32  read data
- mX_err_o  out  1  error; qualified by mX_rvalid_o
- ram_en_o  out  1  RAM enable
- ram_addr_o  out  ADDR_WIDTH  byte address = mX_addr_i[ADDR_WIDTH-1:0]
- ram_wdata_o  out  32  write data
- ram_we_o  out  1  write enable
- ram_be_o  out  4  byte enables
- ram_rdata_i  in  32  read data, valid the cycle after ram_en_o
- ram_bypass_en_o  out  1  constant 0

Behaviour:
- Reset values:
  - Registers: rr_last=1 (m0 wins the first tie), resp_valid=0, resp_owner=0, resp_err=0, rdata_hold=0.
  - Outputs: all gnt/rvalid/err/ram_* outputs read 0.
- Arbitration:
  - Single requester is granted the same cycle.
  - Both requesting: grant goes to the master not equal to rr_last.
  - rr_last updates on every grant.
  - At most one gnt per cycle.
  - Accepted transaction = req & gnt.
- Decode: in_range = (addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]).
- Accepted and in_range:
  - ram_en_o=1; ram_addr/we/be/wdata driven combinationally from the winner.
- Accepted and out of range:
  - ram_en_o=0, ram_we_o=0.
  - Response err=1, rdata=0.
- No accepted transaction: ram_en_o=0, ram_we_o=0; other RAM outputs don't-care but held at the m0 mux value.
- Response timing:
  - Exactly cycle N+1 after acceptance at cycle N, for reads and writes alike.
  - Registered resp_valid/resp_owner/resp_err drive the response.
  - mX_rvalid_o = resp_valid & (resp_owner==X).
- Read data:
  - Both mX_rdata_o are driven from one shared value.
  - resp_valid & ~resp_err: ram_rdata_i.
  - resp_valid & resp_err: 0.
  - Otherwise: rdata_hold, which captures the driven value whenever resp_valid.
  - Write responses return the RAM output, with don't-care content.
- Throughput and ordering:
  - Back-to-back acceptance every cycle; there is no stall path.
  - A master may receive its response in the same cycle as its next grant.
- Reset mid-operation: a pending response is discarded; no rvalid after rstn_i deasserts.
- Width rules: bits above ADDR_WIDTH are used only for decode; no address arithmetic.

Decomposition:
- Package sp_ram_arb_pkg holds:
  - typedef obi_req_t (addr, we, be, wdata);
  - typedef obi_rsp_t (rvalid, rdata, err);
  - localparam NUM_MASTERS=2.
- Sub-module rr_arb2: 2-way round-robin arbiter with req[1:0], gnt[1:0], and the rr_last flop.

Test Plan:
- m1 write 0x0010_0040 be=4'hF data=0xDEADBEEF, then m0 read 0x0010_0040 -> m1_gnt same cycle, m1_rvalid next cycle err=0; m0_rdata=0xDEADBEEF with rvalid one cycle after grant.
- m0 and m1 both request continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; one rvalid per cycle to the correct owner.
- m1 byte write be=4'b0100 data=0x00AB0000 over 0x11223344 -> readback 0x11AB3344.
- m0 read 0x0000_0000 (out of window) -> ram_en_o stays 0; m0_rvalid=1, m0_err=1, m0_rdata=0 next cycle.
- Read 0x0010_7FFC (last word) -> in range, ram_addr_o=15'h7FFC; read 0x0010_8000 -> err=1.
- Assert rstn_i low in the cycle after a grant -> no rvalid ever asserted for that request; all outputs 0; the first tie after reset goes to m0.
